// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the serial pattern generator (seq_gen),
// the pattern detector (seq_det) and their benches.
//   state_t      - 2-bit FSM state encoding
//   IDLE/SEND/GAP/DONE - state constants
//   DET_PATTERN  - the 4-bit sequence recognised by seq_det
package seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t SEND = 2'b01;
  localparam state_t GAP  = 2'b10;
  localparam state_t DONE = 2'b11;

  localparam logic [3:0] DET_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: control/data bundle between a frame controller and seq_gen.
//   start      - request a frame (controller -> generator)
//   pattern    - PAT_W-bit pattern, MSB sent first
//   repeat_cnt - number of pattern repetitions (0 = empty frame)
//   gap        - idle cycles between repetitions
//   dout       - serial data (generator -> consumer)
//   valid      - dout carries a pattern bit
//   busy       - frame in progress
//   done       - one-cycle pulse after frame completion
// Modports: master = controller side, slave = generator side.
interface seq_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             dout;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, gap,
    input  dout, valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap,
    output dout, valid, busy, done
  );

endinterface

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: W-bit parallel-load, MSB-first shift register.
//   i_clk   - rising-edge clock
//   i_rst_n - asynchronous active-low reset (clears to 0)
//   i_load  - load i_data (takes priority over shift)
//   i_shift - shift left by one, filling with 0
//   i_data  - parallel load value
//   o_msb   - current MSB (the bit on the serial line)
// Zero fill means the MSB drops to 0 once all bits have been shifted out,
// so the owner can use o_msb directly as an idle-low serial output.
module seq_gen_shreg #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_shift_in;

  assign w_shift_in = {r_q[W-2:0], 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_q[gi] <= 1'b0;
        end else if (i_load) begin
          r_q[gi] <= i_data[gi];
        end else if (i_shift) begin
          r_q[gi] <= w_shift_in[gi];
        end
      end
    end
  endgenerate

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter. Sends a latched PAT_W-bit pattern
// MSB-first, repeat_cnt times, with gap idle cycles between repetitions.
//   i_clk   - rising-edge clock
//   i_rst_n - asynchronous active-low reset
//   bus     - seq_gen_if.slave: start/pattern/repeat_cnt/gap in,
//             dout/valid/busy/done out (all registered)
module seq_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  seq_gen_if.slave    bus
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  state_t           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [CNT_W-1:0] r_rep_left;
  logic [GAP_W-1:0] r_gap_cfg;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [IDX_W-1:0] r_bit_idx;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_rep_next;
  logic [GAP_W-1:0] w_gap_cnt_next;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_accept;
  logic             w_load;
  logic             w_shift;
  logic [PAT_W-1:0] w_load_data;
  logic             w_msb;

  always_comb begin
    w_state_next   = r_state;
    w_rep_next     = r_rep_left;
    w_gap_cnt_next = r_gap_cnt;
    w_idx_next     = r_bit_idx;
    w_accept       = 1'b0;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept   = 1'b1;
          w_rep_next = bus.repeat_cnt;
          if (bus.repeat_cnt != '0) begin
            w_state_next = SEND;
            w_idx_next   = LAST_IDX;
            w_load       = 1'b1;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      SEND: begin
        if (r_bit_idx == '0) begin
          w_rep_next = r_rep_left - CNT_W'(1);
          if (r_rep_left == CNT_W'(1)) begin
            w_state_next = DONE;
            w_shift      = 1'b1;
          end else if (r_gap_cfg == '0) begin
            // Reload in the same edge so the next repetition follows
            // without a bubble.
            w_idx_next = LAST_IDX;
            w_load     = 1'b1;
          end else begin
            w_state_next   = GAP;
            w_gap_cnt_next = r_gap_cfg;
            w_shift        = 1'b1;
          end
        end else begin
          w_idx_next = r_bit_idx - IDX_W'(1);
          w_shift    = 1'b1;
        end
      end
      GAP: begin
        // Shift register is already all-zero here, so dout idles low.
        if (r_gap_cnt == GAP_W'(1)) begin
          w_state_next   = SEND;
          w_idx_next     = LAST_IDX;
          w_gap_cnt_next = '0;
          w_load         = 1'b1;
        end else begin
          w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // First load comes straight from the bus; later reloads use the latched copy.
  assign w_load_data = (r_state == IDLE) ? bus.pattern : r_pattern;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_pattern  <= '0;
      r_rep_left <= '0;
      r_gap_cfg  <= '0;
      r_gap_cnt  <= '0;
      r_bit_idx  <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rep_left <= w_rep_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_bit_idx  <= w_idx_next;
      if (w_accept) begin
        r_pattern <= bus.pattern;
        r_gap_cfg <= bus.gap;
      end
      // Outputs are decoded from the next state so they align with it.
      r_valid <= (w_state_next == SEND);
      r_busy  <= (w_state_next == SEND) || (w_state_next == GAP);
      r_done  <= (w_state_next == DONE);
    end
  end

  seq_gen_shreg #(
    .W (PAT_W)
  ) u_shreg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (w_msb)
  );

  assign bus.dout  = w_msb;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed bench for seq_gen. Each frame is described by a
// hand-written table of per-cycle nibbles {dout,valid,busy,done}, starting
// with the cycle after the accepting edge.
module tb_seq_gen;
  import seq_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_gen_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

  seq_gen #(
    .PAT_W (4),
    .CNT_W (8),
    .GAP_W (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.dout, bus.valid, bus.busy, bus.done};
  endfunction

  // Launch a frame and compare n cycles against vec (first nibble = cycle k+1).
  // If inj >= 0, start is raised during that cycle with other settings.
  task automatic run_frame(input string tag, input logic [3:0] pat,
                           input logic [7:0] rep, input logic [3:0] gp,
                           input logic [127:0] vec, input int n, input int inj,
                           input logic [3:0] inj_pat, input logic [7:0] inj_rep);
    logic [3:0] exp_n;
    bus.pattern    = pat;
    bus.repeat_cnt = rep;
    bus.gap        = gp;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_n = vec[4*(n-1-i) +: 4];
      check($sformatf("%s c%0d", tag, i + 1), 32'(outs()), 32'(exp_n));
      if (i == inj) begin
        bus.start      = 1'b1;
        bus.pattern    = inj_pat;
        bus.repeat_cnt = inj_rep;
        bus.gap        = 4'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    $display("frame %s pat=%b rep=%0d gap=%0d: %0d cycles compared", tag, pat, rep, gp, n);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.pattern    = '0;
    bus.repeat_cnt = '0;
    bus.gap        = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset outs", 32'(outs()), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle outs", 32'(outs()), 32'h0);
    $display("reset released");

    // 1011 once: bits 1,0,1,1 then done, then idle
    run_frame("single", DET_PATTERN, 8'd1, 4'd0, 128'hE6EE10, 6, -1, 4'h0, 8'd0);
    // 1011 twice, no gap: contiguous 8 bits
    run_frame("b2b", DET_PATTERN, 8'd2, 4'd0, 128'hE6EEE6EE10, 10, -1, 4'h0, 8'd0);
    // 1011 twice, gap 3: three busy-only idle cycles between
    run_frame("gap3", DET_PATTERN, 8'd2, 4'd3, 128'hE6EE222E6EE10, 13, -1, 4'h0, 8'd0);
    // empty frame: done in k+1 only
    run_frame("empty", 4'b1111, 8'd0, 4'd5, 128'h100, 3, -1, 4'h0, 8'd0);
    // 0110 three times, gap 1
    run_frame("gap1x3", 4'b0110, 8'd3, 4'd1, 128'h6EE626EE626EE610, 16, -1, 4'h0, 8'd0);
    // start during second bit with other settings: ignored
    run_frame("midstart", DET_PATTERN, 8'd1, 4'd0, 128'hE6EE10, 6, 1, 4'b0110, 8'd3);
    // start during the DONE cycle: ignored
    run_frame("donestart", DET_PATTERN, 8'd1, 4'd0, 128'hE6EE100, 7, 4, 4'b0110, 8'd2);

    // Reset asserted between edges during the second bit.
    bus.pattern    = DET_PATTERN;
    bus.repeat_cnt = 8'd2;
    bus.gap        = 4'd0;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("abort bit1", 32'(outs()), 32'hE);
    @(posedge clk); #1;
    check("abort bit2", 32'(outs()), 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort async", 32'(outs()), 32'h0);
    @(posedge clk); #1;
    check("abort held", 32'(outs()), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort no done", 32'(outs()), 32'h0);
    $display("reset abort mid-frame");
    run_frame("post-reset", 4'b0110, 8'd1, 4'd0, 128'h6EE610, 6, -1, 4'h0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter that drives the single-bit `din` input of `seq_det` (and any other serial consumer). It emits a PAT_W-bit pattern MSB-first, one bit per clock, repeated a programmable number of times with an optional idle gap between repetitions. A start/busy/done handshake lets a controller or bench launch frames without tracking timing.

## Interface
- PAT_W, 4, pattern width in bits (≥2)
- CNT_W, 8, width of repeat count
- GAP_W, 4, width of inter-repetition gap count
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a frame; sampled on rising edge, honoured only in IDLE
- pattern  input  PAT_W  pattern; bit PAT_W-1 is sent first; sampled only at accept
- repeat_cnt  input  CNT_W  number of pattern repetitions; sampled at accept; 0 = empty frame
- gap  input  GAP_W  idle cycles between repetitions; sampled at accept; 0 = back-to-back
- dout  output  1  serial data; 0 when not sending a pattern bit
- valid  output  1  high exactly in cycles where dout carries a pattern bit
- busy  output  1  high from the cycle after accept through the last pattern bit
- done  output  1  one-cycle pulse after frame completion

## Operation
- All outputs are registered. Reset (reset=0) forces state IDLE and dout=0, valid=0, busy=0, done=0 immediately, regardless of clock. Internal pattern/counter registers clear to 0.
- States (2-bit): IDLE, SEND, GAP, DONE.
- IDLE: If start=1 at an edge, pattern, repeat_cnt and gap are latched (accept). If repeat_cnt≠0, go to SEND, bit index = PAT_W-1, and repetitions left = repeat_cnt. If repeat_cnt=0, go to DONE without asserting busy or valid.
- SEND: dout = latched pattern[bit index], valid=1, busy=1. The bit index decrements each cycle. On the cycle carrying bit 0, repetitions left decrements:
  - If the repetition just finished was the last, go to DONE.
  - Otherwise, if gap=0, stay in SEND with bit index reloaded to PAT_W-1, so there is no bubble.
  - Otherwise, go to GAP with the gap counter = gap.
- GAP: dout=0, valid=0, busy=1. The gap counter decrements; after exactly `gap` cycles, enter SEND with bit index PAT_W-1.
- DONE: held for exactly one cycle with done=1, busy=0, valid=0, dout=0; then IDLE.
- start is ignored in SEND, GAP and DONE. A new frame can be accepted at the first IDLE edge.
- Counter arithmetic is unsigned, decrement-only, and never wraps. Terminal tests are ==1 (or index==0) before decrement. Maximum frame: repeat_cnt = 2^CNT_W−1 repetitions with gap = 2^GAP_W−1.
- Pattern/repeat/gap inputs may change freely while busy; the frame uses the latched copies.

## Timing
- Accept at edge k: the first pattern bit appears on dout/valid/busy after edge k (cycle k+1).
- A frame with R repetitions and gap G occupies R·PAT_W + (R−1)·G cycles of busy=1, followed by one cycle of done=1.
- repeat_cnt=0: done pulses in cycle k+1; busy stays 0.
- Minimum start-to-start spacing for back-to-back frames is busy cycles + 2 (DONE + accepting IDLE edge).
- Reset mid-frame aborts immediately; no done pulse is produced. The first accept after reset release behaves as from power-up.
- dout changes only on rising edges (except async reset), so a downstream detector sampling on the same rising edge sees stable data.

## Structure
- Shared package `seq_pkg`: state typedef/encoding (IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11), and constant DET_PATTERN=4'b1011. DET_PATTERN is the sequence `seq_det` recognises and is shared by both blocks and their benches.
- One sub-module: `seq_gen_shreg`, a PAT_W-bit parallel-load, MSB-first shift register with load/shift enables. The FSM, repeat counter and gap counter stay in `seq_gen`.

## Test plan
- Reset held, then released, start with pattern=4'b1011, repeat_cnt=1, gap=0: dout=1,0,1,1 in cycles k+1..k+4 with valid=busy=1; done=1 in k+5 only.
- Same frame fed into `seq_det.din`: `seq_det.dout` asserts once after the fourth bit. Then repeat_cnt=2, gap=0: dout=10111011 contiguous, valid never drops, detector fires twice (overlap rules per `seq_det`).
- pattern=4'b1011, repeat_cnt=2, gap=3: dout=1011 000 1011; valid=0 and busy=1 for the 3 gap cycles; busy high 11 cycles total; one done pulse.
- repeat_cnt=0 with start: done=1 in cycle k+1; busy, valid and dout remain 0 throughout.
- start pulsed again mid-frame with different pattern/repeat_cnt: ignored; the original frame completes unchanged. Start pulsed in the DONE cycle is also ignored.
- reset driven low between clock edges during the second bit: dout, valid, busy and done go 0 without waiting for a clock edge; no done pulse. After release, a new 4'b0110 frame is sent correctly.
